// File: rtl/shift_ctrl_pkg.sv
// Shared types and defaults for the shifter sequencing controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: FSM state enum, shift direction encodings, default widths.
package shift_ctrl_pkg;

    localparam int WIDTH_DEF = 4;   // shifter data width
    localparam int CNT_W_DEF = 3;   // shift-amount width, max amount 2^CNT_W-1

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter with a last-grant pointer.
// Latency: grant is combinational from req; pointer updates on the accept edge.
// Backpressure: grant is a proposal only; the pointer moves only when accept is high.
//
// Ports:
//   clk, rst_n   clock, async active-low reset (pointer favours req[0] after reset)
//   req[1:0]     request vector
//   accept       the granted request was taken this cycle
//   grant[1:0]   one-hot grant, zero when no request
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    // 1 = requester 1 was granted last. Resetting to 1 makes requester 0
    // win the first contended cycle.
    logic last_q;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_q ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (accept) begin
            last_q <= grant[1];
        end
    end

endmodule

// File: rtl/shift_ctrl.sv
// Sequences multi-step shift commands from two requesters onto the shifter strobes.
// Latency: accept at T, strobes T+1..T+amt, done pulse at T+amt+2 (amt=0 included).
// Backpressure: reqN_ready only in IDLE for the arbitrated requester; one command in flight.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   reqN_valid/dir/amt/ready    command handshake per requester (dir 0=left, 1=right)
//   shift_left, shift_right     shifter step strobes, one step per high cycle
//   shifter_out                 shifter data word, sampled at completion
//   busy                        command in progress
//   done, done_id, result       completion pulse, requester tag, captured word
module shift_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic             req0_dir,
    input  logic [CNT_W-1:0] req0_amt,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic             req1_dir,
    input  logic [CNT_W-1:0] req1_amt,
    output logic             req1_ready,
    output logic             shift_left,
    output logic             shift_right,
    input  logic [WIDTH-1:0] shifter_out,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] result
);

    // Latched command attributes; the amount lives in the step counter.
    typedef struct packed {
        logic id;
        logic dir;
    } cmd_t;

    state_t           state_q, state_nxt;
    cmd_t             cmd_q, cmd_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;

    logic [1:0]       req_vld;
    logic [1:0]       grant;
    logic [1:0]       rdy;
    logic             accept;
    logic [CNT_W-1:0] amt_sel;
    logic             dir_sel;

    assign req_vld = {req1_valid, req0_valid};

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req_vld),
        .accept (accept),
        .grant  (grant)
    );

    // grant is already zero for an idle requester, so masking with req_vld
    // only guards against any future change of the arbiter.
    assign rdy        = (state_q == IDLE) ? (grant & req_vld) : 2'b00;
    assign req0_ready = rdy[0];
    assign req1_ready = rdy[1];
    assign accept     = |rdy;

    assign amt_sel = rdy[1] ? req1_amt : req0_amt;
    assign dir_sel = rdy[1] ? req1_dir : req0_dir;

    // Next-state / datapath decode.
    always_comb begin
        state_nxt = state_q;
        cmd_nxt   = cmd_q;
        cnt_nxt   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cmd_nxt.id  = rdy[1];
                    cmd_nxt.dir = dir_sel;
                    cnt_nxt     = amt_sel;
                    state_nxt   = (amt_sel != '0) ? SHIFT : SETTLE;
                end
            end
            SHIFT: begin
                cnt_nxt = cnt_q - 1'b1;
                // The cycle holding count 1 is the last strobe cycle.
                if (cnt_q == CNT_W'(1)) begin
                    state_nxt = SETTLE;
                end
            end
            SETTLE:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Command latch, counter and registered outputs. Outputs are decoded from
    // the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q       <= '0;
            cnt_q       <= '0;
            shift_left  <= 1'b0;
            shift_right <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            done_id     <= 1'b0;
            result      <= '0;
        end else begin
            cmd_q       <= cmd_nxt;
            cnt_q       <= cnt_nxt;
            shift_left  <= (state_nxt == SHIFT) && (cmd_nxt.dir == DIR_LEFT);
            shift_right <= (state_nxt == SHIFT) && (cmd_nxt.dir == DIR_RIGHT);
            busy        <= (state_nxt != IDLE);
            done        <= (state_nxt == DONE);
            done_id     <= (state_nxt == DONE) ? cmd_q.id : 1'b0;
            // The shifter has absorbed the last strobe by the SETTLE cycle.
            if (state_q == SETTLE) begin
                result <= shifter_out;
            end
        end
    end

endmodule

// File: tb/tb_shift_ctrl.sv
// Self-checking bench for shift_ctrl: directed cases plus randomized two-requester traffic.
// Latency: n/a.
// Backpressure: requesters hold valid and fields until ready is observed.
module tb_shift_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       req0_valid = 1'b0, req0_dir = 1'b0;
    logic [2:0] req0_amt = '0;
    logic       req1_valid = 1'b0, req1_dir = 1'b0;
    logic [2:0] req1_amt = '0;
    logic       req0_ready, req1_ready;
    logic       shift_left, shift_right;
    logic       busy, done, done_id;
    logic [3:0] result;

    // Shifter environment model (rotating 4-bit register with a load port).
    logic [3:0] sh = 4'b0001;
    logic       sh_load = 1'b0;
    logic [3:0] sh_val = '0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    shift_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_dir    (req0_dir),
        .req0_amt    (req0_amt),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_dir    (req1_dir),
        .req1_amt    (req1_amt),
        .req1_ready  (req1_ready),
        .shift_left  (shift_left),
        .shift_right (shift_right),
        .shifter_out (sh),
        .busy        (busy),
        .done        (done),
        .done_id     (done_id),
        .result      (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (sh_load)          sh <= sh_val;
        else if (shift_left)  sh <= {sh[2:0], sh[3]};
        else if (shift_right) sh <= {sh[0], sh[3:1]};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Rotation by n steps, written as repeated single-step moves.
    function automatic logic [3:0] rot(input logic [3:0] v, input int n, input logic d);
        logic [3:0] r;
        r = v;
        for (int i = 0; i < n; i++) begin
            r = d ? {r[0], r[3:1]} : {r[2:0], r[3]};
        end
        return r;
    endfunction

    // ---------------- reference model (transaction level) ----------------
    logic       act = 1'b0;
    int         a_t = 0, a_amt = 0, scnt = 0;
    logic       a_dir = 1'b0, a_id = 1'b0;
    logic [3:0] a_exp = '0, last_res = '0;
    logic       last_ptr = 1'b1;
    int         acc_q[$];
    int         done_q[$];
    logic       gnt_q[$];
    logic       did_q[$];

    always @(negedge clk) begin
        logic [1:0] v, g;
        logic       idle, win, dn;
        v = {req1_valid, req0_valid};
        if (!rst_n) begin
            act      = 1'b0;
            last_ptr = 1'b1;
            last_res = '0;
            idle     = 1'b1;
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_done_id", done_id, 0);
            chk("rst_strobes", {shift_left, shift_right}, 0);
            chk("rst_result", result, 0);
        end else begin
            idle = !act;
            win  = act && (cyc >= a_t + 1) && (cyc <= a_t + a_amt);
            chk("strobe_excl", shift_left & shift_right, 0);
            chk("shift_left", shift_left, win && !a_dir);
            chk("shift_right", shift_right, win && a_dir);
            if (win && (shift_left || shift_right)) scnt++;
            chk("busy", busy, act && (cyc >= a_t + 1));
            dn = act && (cyc == a_t + a_amt + 2);
            chk("done", done, dn);
            if (dn) begin
                chk("done_id", done_id, a_id);
                chk("result", result, a_exp);
                chk("strobe_count", scnt, a_amt);
                done_q.push_back(cyc);
                did_q.push_back(a_id);
                last_res = a_exp;
                act      = 1'b0;
            end else begin
                chk("result_hold", result, last_res);
            end
        end
        g = (v == 2'b11) ? (last_ptr ? 2'b01 : 2'b10) : v;
        if (!idle) g = 2'b00;
        chk("req0_ready", req0_ready, g[0]);
        chk("req1_ready", req1_ready, g[1]);
        if (rst_n && g != 2'b00) begin
            act      = 1'b1;
            a_t      = cyc;
            a_id     = g[1];
            a_dir    = g[1] ? req1_dir : req0_dir;
            a_amt    = int'(g[1] ? req1_amt : req0_amt);
            a_exp    = rot(sh, a_amt, a_dir);
            scnt     = 0;
            last_ptr = g[1];
            acc_q.push_back(cyc);
            gnt_q.push_back(g[1]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic id, input logic dir, input logic [2:0] amt);
        logic got;
        got = 1'b0;
        if (id) begin req1_valid = 1'b1; req1_dir = dir; req1_amt = amt; end
        else    begin req0_valid = 1'b1; req0_dir = dir; req0_amt = amt; end
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = id ? req1_ready : req0_ready;
        end
        chk("send_accept", got, 1);
        @(posedge clk);
        #1;
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
    endtask

    task automatic wait_dones(input int target);
        for (int i = 0; i < 100 && done_q.size() < target; i++) @(posedge clk);
        chk("done_wait", done_q.size() >= target, 1);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic load_sh(input logic [3:0] v);
        @(posedge clk);
        #1 sh_load = 1'b1; sh_val = v;
        @(posedge clk);
        #1 sh_load = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int base, nd;
        logic [3:0] sh_before;

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Left shift of 3 on 0001.
        load_sh(4'b0001);
        base = acc_q.size();
        nd   = done_q.size();
        send(1'b0, 1'b0, 3'd3);
        wait_dones(nd + 1);
        chk("t1_result", result, 4'b1000);
        chk("t1_latency", done_q[nd] - acc_q[base], 5);
        chk("t1_done_id", did_q[nd], 0);

        // Zero-step command from req1.
        sh_before = sh;
        base = acc_q.size();
        nd   = done_q.size();
        send(1'b1, 1'b1, 3'd0);
        wait_dones(nd + 1);
        chk("t2_result", result, sh_before);
        chk("t2_latency", done_q[nd] - acc_q[base], 2);
        chk("t2_done_id", did_q[nd], 1);

        // Contention: both held valid, grants alternate starting with req0.
        do_reset();
        base = gnt_q.size();
        nd   = done_q.size();
        fork
            begin send(1'b0, 1'b0, 3'd2); send(1'b0, 1'b1, 3'd1); end
            begin send(1'b1, 1'b1, 3'd3); send(1'b1, 1'b0, 3'd0); end
        join
        wait_dones(nd + 4);
        for (int i = 0; i < 4; i++) begin
            chk("rr_grant", gnt_q[base + i], i % 2);
            chk("rr_done_id", did_q[nd + i], i % 2);
        end

        // Only req1, three back-to-back commands at the earliest slot.
        begin
            logic [2:0] amts [3];
            amts[0] = 3'd2; amts[1] = 3'd0; amts[2] = 3'd5;
            base = acc_q.size();
            nd   = done_q.size();
            for (int i = 0; i < 3; i++) send(1'b1, 1'b0, amts[i]);
            wait_dones(nd + 3);
            for (int i = 0; i < 2; i++) begin
                chk("b2b_gap", acc_q[base + i + 1] - acc_q[base + i], int'(amts[i]) + 3);
                chk("b2b_id", gnt_q[base + i + 1], 1);
            end
        end

        // Asynchronous reset in the middle of an amt=7 shift.
        nd = done_q.size();
        send(1'b0, 1'b0, 3'd7);
        repeat (2) @(posedge clk);
        #2;
        chk("mid_strobe_on", shift_left, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_strobe", {shift_left, shift_right}, 0);
        chk("mid_rst_busy", busy, 0);
        @(negedge clk);
        req0_valid = 1'b1; req0_dir = 1'b1; req0_amt = 3'd2;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", req0_ready, 1);
        @(posedge clk);
        #1 req0_valid = 1'b0;
        wait_dones(nd + 1);
        chk("post_rst_done_cnt", done_q.size(), nd + 1);

        // Randomized traffic from both requesters.
        load_sh(4'($urandom_range(15, 1)));
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    int gap;
                    gap = $urandom_range(3, 0);
                    if (gap > 0) begin repeat (gap) @(posedge clk); #1; end
                    send(1'b0, 1'($urandom_range(1, 0)), 3'($urandom_range(7, 0)));
                end
            end
            begin
                for (int i = 0; i < 12; i++) begin
                    int gap;
                    gap = $urandom_range(3, 0);
                    if (gap > 0) begin repeat (gap) @(posedge clk); #1; end
                    send(1'b1, 1'($urandom_range(1, 0)), 3'($urandom_range(7, 0)));
                end
            end
        join
        repeat (15) @(posedge clk);
        #1;
        // One command was dropped by the mid-shift reset.
        chk("done_total", done_q.size(), acc_q.size() - 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_ctrl.md
# shift_ctrl

Sequencing controller for the 4-bit shifter datapath. It accepts multi-step shift commands from two requesters over valid/ready handshakes and arbitrates between them round-robin. It drives the shifter's `shift_left`/`shift_right` strobes for the requested number of cycles, then returns the shifter's output word with a one-cycle done pulse tagged with the requester ID. It sits between the command sources and the shifter, and is the only block that drives the shifter's control inputs.

## Interface
- `WIDTH`, 4, shifter data width.
- `CNT_W`, 3, shift-amount width; max amount is 2^CNT_W-1.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req0_valid`, `req1_valid`  in  1  command present.
- `req0_dir`, `req1_dir`  in  1  0 = left, 1 = right.
- `req0_amt`, `req1_amt`  in  CNT_W  number of shift steps.
- `req0_ready`, `req1_ready`  out  1  command accepted this cycle.
- `shift_left`  out  1  shifter left strobe, one step per cycle high.
- `shift_right`  out  1  shifter right strobe, one step per cycle high.
- `shifter_out`  in  WIDTH  shifter data word.
- `busy`  out  1  command in progress (state ≠ IDLE).
- `done`  out  1  one-cycle completion pulse.
- `done_id`  out  1  requester of the completed command.
- `result`  out  WIDTH  `shifter_out` captured at completion; holds until the next completion.

## Operation
- FSM states: IDLE, SHIFT, SETTLE, DONE.
- **IDLE**
  - If either valid is high, grant one requester and accept its command in the same cycle.
  - `reqN_ready` is combinational: high only in IDLE, only for the granted requester, and only when that requester's valid is high.
  - On accept, latch `dir`, `amt` and `id`, and load the counter with `amt`.
  - If `amt` ≠ 0, go to SHIFT; if `amt` = 0, go to SETTLE.
- **SHIFT**
  - Assert `shift_left` if dir = 0, otherwise `shift_right`.
  - Decrement the counter each cycle; leave for SETTLE in the cycle the counter reaches 1.
- **SETTLE**
  - No strobes.
  - Capture `shifter_out` into `result` at the end of this cycle.
- **DONE**
  - `done` = 1, `done_id` = latched id.
  - Go to IDLE. No acceptance happens in DONE.
- **Arbitration**
  - Two-way round-robin with a last-grant pointer.
  - If both valids are high in IDLE, grant the requester not granted last.
  - If only one is valid, grant it regardless of the pointer.
  - Update the pointer only on accept.
- **Rules**
  - `shift_left` and `shift_right` are never high together.
  - Strobes are low outside SHIFT.
  - A requester must hold valid and its fields stable until it sees ready; fields are ignored after accept.
- **Reset** (asynchronous, at any point including mid-shift)
  - State returns to IDLE and the pointer favours req0.
  - `busy`, `done`, `done_id`, `shift_left`, `shift_right` are 0, and `result` is 0.
  - `ready` is then driven by valids per the IDLE rule.
  - An in-flight command is dropped and produces no done.

## Timing
- Accept in cycle T (valid & ready).
- Strobes are high in cycles T+1 … T+amt, exactly `amt` cycles and contiguous.
- SETTLE is cycle T+amt+1; `done` is high in cycle T+amt+2.
- Latency from accept to done is amt+2 cycles, including amt = 0 (done at T+2).
- The earliest next accept is cycle T+amt+3.
- Maximum throughput is one command per amt+3 cycles.
- `busy` is high from T+1 through the DONE cycle inclusive.
- All outputs except `reqN_ready` are registered.

## Structure
- Package `shift_ctrl_pkg` holds:
  - state enum (IDLE, SHIFT, SETTLE, DONE);
  - DIR_LEFT = 0 and DIR_RIGHT = 1;
  - default WIDTH/CNT_W localparams.
- Sub-module `rr_arb2`: two-request round-robin arbiter.
  - Inputs: `req[1:0]`, `accept`, `clk`, `rst_n`.
  - Output: one-hot `grant[1:0]`.
  - Owns the last-grant pointer.
- `shift_ctrl` holds the FSM, counter, command latch and result register.

## Test plan
- Reset then req0 {dir=0, amt=3}, with a shifter model starting at 0001:
  - `req0_ready` is high at T;
  - `shift_left` is high at T+1..T+3;
  - `done` is at T+5 with `done_id` = 0 and `result` = 1000.
- req1 {dir=1, amt=0}:
  - no strobes at any cycle;
  - `done` is at T+2 and `result` equals the unchanged `shifter_out`.
- req0 and req1 held valid continuously after reset:
  - grants alternate 0, 1, 0, 1;
  - each done pulse carries the matching `done_id`;
  - `ready` never occurs during busy.
- Only req1 valid for three commands in a row: all three are granted to req1 back-to-back (earliest allowed accept each time).
- `rst_n` pulsed low asynchronously mid-SHIFT of amt=7:
  - strobes drop immediately and `busy` = 0;
  - no `done` for that command;
  - a new req0 command is accepted in the first cycle after reset release.
- Assertion over all tests: `shift_left` & `shift_right` is never 1, and the strobe count per command equals `amt`.
